// File: rtl/tone_gen_pkg.sv
// tone_gen_pkg: register map, control bit layout and version default for tone_gen
package tone_gen_pkg;
   localparam logic [31:0] ADDR_VER    = 32'h00;
   localparam logic [31:0] ADDR_BUSY   = 32'h04;
   localparam logic [31:0] ADDR_DONE   = 32'h08;
   localparam logic [31:0] ADDR_IRQ_EN = 32'h0C;
   localparam logic [31:0] CH_BASE     = 32'h10;
   localparam logic [31:0] CH_STRIDE   = 32'h10;
   localparam logic [31:0] OFF_CTRL    = 32'h0;
   localparam logic [31:0] OFF_HALF    = 32'h4;
   localparam logic [31:0] OFF_COUNT   = 32'h8;
   localparam logic [31:0] OFF_REMAIN  = 32'hC;
   localparam int CTRL_EN    = 0;
   localparam int CTRL_BURST = 1;
   localparam int CTRL_POL   = 2;
   localparam logic [31:0] HW_VER_DEF = 32'h02;
   function automatic logic [31:0] ch_addr(input int c, input logic [31:0] off);
      return CH_BASE + CH_STRIDE * 32'(c) + off;
   endfunction
endpackage

// File: rtl/tone_gen_ch.sv
// tone_gen_ch: one square-wave channel with prescaler, tone bit and burst period counter
module tone_gen_ch #(
   parameter int CNT_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             arm,
   input  logic             stop,
   input  logic             burst,
   input  logic             pol,
   input  logic [CNT_W-1:0] h,
   input  logic [CNT_W-1:0] n,
   output logic             pin,
   output logic             busy,
   output logic             done_pulse,
   output logic [CNT_W-1:0] rem
);
   logic             t, toggle, fall;
   logic [CNT_W-1:0] psc;
   // the last falling edge and the burst completion land on the same clock
   always_comb begin
      toggle     = busy && h != '0 && psc >= h - CNT_W'(1);
      fall       = toggle && t;
      done_pulse = busy && !arm && !stop && burst && (rem == '0 || (fall && rem == CNT_W'(1)));
      pin        = t ^ pol;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         {busy, t, psc, rem} <= '0;
      end else if (arm) begin
         busy <= 1'b1;
         t    <= 1'b0;
         psc  <= '0;
         rem  <= n;
      end else if (stop || done_pulse) begin
         busy <= 1'b0;
         t    <= 1'b0;
         psc  <= '0;
         if (done_pulse) rem <= '0;
      end else if (busy) begin
         if (h == '0) begin
            t   <= 1'b0;
            psc <= '0;
         end else if (toggle) begin
            t   <= ~t;
            psc <= '0;
            if (fall && burst) rem <= rem - CNT_W'(1);
         end else begin
            psc <= psc + CNT_W'(1);
         end
      end
   end
endmodule

// File: rtl/tone_gen.sv
// tone_gen: register bus front end, DONE/IRQ_EN and read mux around NUM_CH tone channels
module tone_gen
   import tone_gen_pkg::*;
#(
   parameter int          NUM_CH = 2,
   parameter int          CNT_W  = 24,
   parameter logic [31:0] HW_VER = HW_VER_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  logic [31:0]       waddr,
   input  logic [31:0]       wdata,
   input  logic              rd,
   input  logic [31:0]       raddr,
   output logic [31:0]       rdata,
   output logic              irq,
   output logic [NUM_CH-1:0] buzzer_pin
);
   logic [NUM_CH-1:0]       busy, dp, done, irq_en;
   logic [NUM_CH-1:0][31:0] rd_ch;
   logic [31:0]             rval;
   logic                    unused_ok;
   assign unused_ok = &{1'b0, wdata};
   assign irq = |(done & irq_en);
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [2:0]       ctrl;
      logic [CNT_W-1:0] half, count, rem;
      logic             wr_ctrl;
      assign wr_ctrl = wr && waddr == ch_addr(g, OFF_CTRL);
      always_ff @(posedge clk) begin
         if (rst) begin
            ctrl  <= '0;
            half  <= '0;
            count <= '0;
         end else begin
            if (wr_ctrl) ctrl <= wdata[2:0];
            else if (dp[g]) ctrl[CTRL_EN] <= 1'b0;
            if (wr && waddr == ch_addr(g, OFF_HALF)) half <= wdata[CNT_W-1:0];
            if (wr && waddr == ch_addr(g, OFF_COUNT)) count <= wdata[CNT_W-1:0];
         end
      end
      tone_gen_ch #(.CNT_W(CNT_W)) u_ch (
         .clk        (clk),
         .rst        (rst),
         .arm        (wr_ctrl && wdata[CTRL_EN]),
         .stop       (wr_ctrl && !wdata[CTRL_EN]),
         .burst      (ctrl[CTRL_BURST]),
         .pol        (ctrl[CTRL_POL]),
         .h          (half),
         .n          (count),
         .pin        (buzzer_pin[g]),
         .busy       (busy[g]),
         .done_pulse (dp[g]),
         .rem        (rem)
      );
      assign rd_ch[g] = raddr == ch_addr(g, OFF_CTRL)   ? 32'(ctrl)  :
                        raddr == ch_addr(g, OFF_HALF)   ? 32'(half)  :
                        raddr == ch_addr(g, OFF_COUNT)  ? 32'(count) :
                        raddr == ch_addr(g, OFF_REMAIN) ? 32'(rem)   : '0;
   end
   always_comb begin
      rval = raddr == ADDR_VER    ? HW_VER       :
             raddr == ADDR_BUSY   ? 32'(busy)    :
             raddr == ADDR_DONE   ? 32'(done)    :
             raddr == ADDR_IRQ_EN ? 32'(irq_en)  : '0;
      for (int i = 0; i < NUM_CH; i++) rval = rval | rd_ch[i];
   end
   // a completion landing on the same edge as its W1C clear stays set
   always_ff @(posedge clk) begin
      if (rst) begin
         done   <= '0;
         irq_en <= '0;
         rdata  <= '0;
      end else begin
         done <= (done & ~(wr && waddr == ADDR_DONE ? wdata[NUM_CH-1:0] : '0)) | dp;
         if (wr && waddr == ADDR_IRQ_EN) irq_en <= wdata[NUM_CH-1:0];
         if (rd) rdata <= rval;
      end
   end
endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen: directed and random register traffic checked every cycle against a time-based tone model
module tb_tone_gen;
   localparam int NCH = 2;
   localparam int CW  = 24;
   logic            clk = 0, rst = 1, wr = 0, rd = 0;
   logic [31:0]     waddr = 0, wdata = 0, raddr = 0;
   logic [31:0]     rdata;
   logic            irq;
   logic [NCH-1:0]  buzzer_pin;
   int n_tests = 0, n_fail = 0;
   bit chk = 0;
   tone_gen dut (
      .clk(clk), .rst(rst), .wr(wr), .waddr(waddr), .wdata(wdata),
      .rd(rd), .raddr(raddr), .rdata(rdata), .irq(irq), .buzzer_pin(buzzer_pin)
   );
   always #5 clk = ~clk;
   bit             m_en[NCH], m_burst[NCH], m_pol[NCH], m_run[NCH], m_lvl[NCH];
   logic [CW-1:0]  m_half[NCH], m_count[NCH], m_left[NCH];
   int             m_last[NCH];
   logic [NCH-1:0] m_done = 0, m_irq_en = 0;
   logic [31:0]    m_rdata = 0;
   int             k = 0;
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, k);
      end
   endtask
   function automatic int ch_of(input logic [31:0] a);
      return (a >= 16 && a < 16 + 16 * NCH && a[1:0] == 0) ? int'((a - 16) >> 4) : -1;
   endfunction
   function automatic logic [31:0] mread(input logic [31:0] a);
      int c = ch_of(a);
      logic [NCH-1:0] b;
      for (int i = 0; i < NCH; i++) b[i] = m_run[i];
      if (a == 0) return 32'h2;
      if (a == 4) return 32'(b);
      if (a == 8) return 32'(m_done);
      if (a == 12) return 32'(m_irq_en);
      if (c < 0) return 0;
      case (a[3:2])
         2'd0: return {29'b0, m_pol[c], m_burst[c], m_en[c]};
         2'd1: return 32'(m_half[c]);
         2'd2: return 32'(m_count[c]);
         default: return 32'(m_left[c]);
      endcase
   endfunction
   function automatic logic [NCH-1:0] m_pins();
      logic [NCH-1:0] p;
      for (int i = 0; i < NCH; i++) p[i] = m_lvl[i] ^ m_pol[i];
      return p;
   endfunction
   // tone edges are scheduled H clocks after the previous edge (or the arm), using the current HALF
   task automatic model_step(input bit w, input logic [31:0] wa, wd, input bit r, input logic [31:0] ra, input bit rs);
      int c;
      logic [NCH-1:0] fin;
      k++;
      if (rs) begin
         for (int i = 0; i < NCH; i++) begin
            m_en[i] = 0; m_burst[i] = 0; m_pol[i] = 0; m_run[i] = 0; m_lvl[i] = 0;
            m_half[i] = 0; m_count[i] = 0; m_left[i] = 0; m_last[i] = 0;
         end
         m_done = 0; m_irq_en = 0; m_rdata = 0;
         return;
      end
      if (r) m_rdata = mread(ra);
      c = w ? ch_of(wa) : -1;
      fin = 0;
      for (int i = 0; i < NCH; i++) begin
         if (c == i && wa[3:2] == 0) begin
            m_lvl[i] = 0;
            m_run[i] = wd[0];
            if (wd[0]) begin m_last[i] = k; m_left[i] = m_count[i]; end
         end else if (m_run[i]) begin
            if (m_burst[i] && m_left[i] == 0) fin[i] = 1;
            else if (m_half[i] == 0) begin m_lvl[i] = 0; m_last[i] = k; end
            else if (k >= m_last[i] + int'(m_half[i])) begin
               m_last[i] = k;
               m_lvl[i] = !m_lvl[i];
               if (!m_lvl[i] && m_burst[i]) begin
                  m_left[i] = m_left[i] - 1;
                  if (m_left[i] == 0) fin[i] = 1;
               end
            end
            if (fin[i]) begin m_run[i] = 0; m_lvl[i] = 0; m_en[i] = 0; end
         end
      end
      if (c >= 0)
         case (wa[3:2])
            2'd0: {m_pol[c], m_burst[c], m_en[c]} = wd[2:0];
            2'd1: m_half[c] = wd[CW-1:0];
            2'd2: m_count[c] = wd[CW-1:0];
            default: ;
         endcase
      if (w && wa == 12) m_irq_en = wd[NCH-1:0];
      m_done = (m_done & ~((w && wa == 8) ? wd[NCH-1:0] : '0)) | fin;
   endtask
   task automatic cyc(input bit w, input logic [31:0] wa, wd, input bit r, input logic [31:0] ra, input bit rs);
      @(negedge clk);
      wr = w; waddr = wa; wdata = wd; rd = r; raddr = ra; rst = rs;
      @(posedge clk);
      model_step(w, wa, wd, r, ra, rs);
      #1;
   endtask
   task automatic wreg(input logic [31:0] a, d); cyc(1, a, d, 0, 0, 0); endtask
   task automatic rreg(input logic [31:0] a); cyc(0, 0, 0, 1, a, 0); endtask
   task automatic idle(input int n); repeat (n) cyc(0, 0, 0, 0, 0, 0); endtask
   always @(negedge clk) begin
      if (chk) begin
         check("pins", 32'(buzzer_pin), 32'(m_pins()));
         check("irq", 32'(irq), 32'(|(m_done & m_irq_en)));
         check("rdata", rdata, m_rdata);
      end
   end
   initial begin
      int rises;
      bit prev;
      cyc(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 1);
      chk = 1;
      check("rst_pins", 32'(buzzer_pin), 0);
      check("rst_irq", 32'(irq), 0);
      check("rst_rdata", rdata, 0);
      rreg(32'h00);
      check("ver", rdata, 32'h2);
      wreg(32'h14, 3);
      wreg(32'h10, 1);
      for (int j = 1; j <= 12; j++) begin
         idle(1);
         check("tone0", 32'(buzzer_pin[0]), 32'((j / 3) % 2));
      end
      wreg(32'h10, 0);
      check("stop_pin", 32'(buzzer_pin[0]), 0);
      rreg(32'h08);
      check("stop_done", rdata, 0);
      wreg(32'h24, 2);
      wreg(32'h28, 3);
      wreg(32'h0C, 2);
      wreg(32'h20, 3);
      rises = 0;
      prev = 0;
      for (int j = 1; j <= 12; j++) begin
         idle(1);
         if (buzzer_pin[1] && !prev) rises++;
         prev = buzzer_pin[1];
         if (j == 11) check("irq_e11", 32'(irq), 0);
         if (j == 12) check("irq_e12", 32'(irq), 1);
      end
      check("pulses", 32'(rises), 3);
      rreg(32'h04);
      check("busy_end", rdata, 0);
      rreg(32'h2C);
      check("remain", rdata, 0);
      wreg(32'h08, 2);
      check("irq_clr", 32'(irq), 0);
      wreg(32'h10, 3);
      check("n0_pin_a", 32'(buzzer_pin[0]), 0);
      idle(1);
      check("n0_pin_b", 32'(buzzer_pin[0]), 0);
      rreg(32'h08);
      check("n0_done", rdata, 32'h1);
      wreg(32'h10, 3);
      wreg(32'h08, 1);
      rreg(32'h08);
      check("set_wins", rdata, 32'h1);
      wreg(32'h08, 1);
      rreg(32'h08);
      check("w1c", rdata, 0);
      wreg(32'h14, 10);
      wreg(32'h10, 1);
      idle(7);
      wreg(32'h14, 4);
      check("half_e8", 32'(buzzer_pin[0]), 0);
      idle(1);
      check("half_e9", 32'(buzzer_pin[0]), 1);
      idle(3);
      check("half_e12", 32'(buzzer_pin[0]), 1);
      idle(1);
      check("half_e13", 32'(buzzer_pin[0]), 0);
      idle(4);
      check("half_e17", 32'(buzzer_pin[0]), 1);
      wreg(32'h10, 4);
      check("pol_idle", 32'(buzzer_pin[0]), 1);
      wreg(32'h10, 0);
      wreg(32'h0C, 3);
      wreg(32'h24, 5);
      wreg(32'h28, 4);
      wreg(32'h18, 0);
      wreg(32'h10, 3);
      idle(2);
      check("irq_pre_rst", 32'(irq), 1);
      wreg(32'h20, 3);
      idle(7);
      check("pin1_mid", 32'(buzzer_pin[1]), 1);
      cyc(0, 0, 0, 0, 0, 1);
      check("mid_rst_pins", 32'(buzzer_pin), 0);
      check("mid_rst_irq", 32'(irq), 0);
      rreg(32'h00);
      rreg(32'h04);
      check("mid_rst_busy", rdata, 0);
      rreg(32'h08);
      check("mid_rst_done", rdata, 0);
      wreg(32'h34, 7);
      rreg(32'h34);
      check("oor_read", rdata, 0);
      wreg(32'h14, 32'hFF000002);
      rreg(32'h14);
      check("trunc", rdata, 32'h000002);
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] a, d, ra;
         int c, o;
         c = $urandom_range(0, NCH);
         o = $urandom_range(0, 3);
         a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3) * 4) : 32'(16 + 16 * c + 4 * o);
         if ($urandom_range(0, 49) == 0) a = 32'h41;
         if (a[3:2] == 0 && a >= 16) begin
            d = 32'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 6) d[0] = 1'b1;
         end else begin
            d = 32'($urandom_range(0, 5));
            if ($urandom_range(0, 7) == 0) d = {8'($urandom), 24'($urandom_range(0, 5))};
         end
         ra = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3) * 4)
                                          : 32'(16 + 16 * $urandom_range(0, NCH) + 4 * $urandom_range(0, 3));
         cyc($urandom_range(0, 2) == 0, a, d, $urandom_range(0, 1) == 1, ra, $urandom_range(0, 399) == 0);
      end
      idle(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
